// File: rtl/fft_rescale_scheduler_pkg.sv
// Shared types and constants for the FFT block-floating-point rescale scheduler.
package fft_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_RUN,
        SCHED_STAGE_END,
        SCHED_DONE
    } sched_state_e;

    localparam logic RESCALE_MODE_ADAPTIVE = 1'b0;
    localparam logic RESCALE_MODE_ALWAYS   = 1'b1;

endpackage

// File: rtl/fft_rescale_scheduler_if.sv
// Control/status bundle between FFT top-level control (master) and the rescale scheduler (slave).
interface fft_rescale_scheduler_if #(
    parameter int FFT_LENGTH             = 1024,
    parameter int FFT_SCALE_FACTOR_WIDTH = 8
);
    localparam int STAGES = $clog2(FFT_LENGTH);
    localparam int STG_W  = $clog2(STAGES) + 1;
    localparam int CNT_W  = $clog2(FFT_LENGTH) + 1;

    logic                              start_i;
    logic                              abort_i;
    logic                              mode_i;
    logic [7:0]                        threshold_i;
    logic                              sample_valid_i;
    logic                              overflow_i;
    logic [STG_W-1:0]                  stage_o;
    logic                              rescale_en_o;
    logic                              scale_track_en_o;
    logic                              busy_o;
    logic                              stage_done_o;
    logic                              done_o;
    logic [FFT_SCALE_FACTOR_WIDTH-1:0] scale_exp_o;
    logic [CNT_W-1:0]                  stage_ovf_cnt_o;
    logic                              err_o;

    modport master (
        output start_i, abort_i, mode_i, threshold_i, sample_valid_i, overflow_i,
        input  stage_o, rescale_en_o, scale_track_en_o, busy_o, stage_done_o, done_o,
               scale_exp_o, stage_ovf_cnt_o, err_o
    );

    modport slave (
        input  start_i, abort_i, mode_i, threshold_i, sample_valid_i, overflow_i,
        output stage_o, rescale_en_o, scale_track_en_o, busy_o, stage_done_o, done_o,
               scale_exp_o, stage_ovf_cnt_o, err_o
    );

endinterface

// File: rtl/fft_rescale_scheduler_stage_counter.sv
// Per-stage sample down-counter with terminal-count flag and a saturating overflow counter.
module fft_stage_counter #(
    parameter int LENGTH = 1024,
    parameter int CNT_W  = $clog2(LENGTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr,
    input  logic             en,
    input  logic             ovf,
    output logic             last_sample,
    output logic [CNT_W-1:0] ovf_cnt
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LENGTH - 1);

    logic [CNT_W-1:0] remain_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            remain_q <= LOAD;
            ovf_cnt  <= '0;
        end else if (clr) begin
            remain_q <= LOAD;
            ovf_cnt  <= '0;
        end else if (en) begin
            remain_q <= remain_q - CNT_W'(1);
            if (ovf && ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

    assign last_sample = (remain_q == '0);

endmodule

// File: rtl/fft_rescale_scheduler.sv
// Stage sequencer for block-floating-point rescaling across the radix-2 FFT stages.
module fft_rescale_scheduler
    import fft_pkg::*;
#(
    parameter int FFT_LENGTH             = 1024,
    parameter int FFT_SCALE_FACTOR_WIDTH = 8
) (
    input logic                     clk_i,
    input logic                     reset_i,
    fft_rescale_scheduler_if.slave  bus
);
    localparam int STAGES = $clog2(FFT_LENGTH);
    localparam int STG_W  = $clog2(STAGES) + 1;
    localparam int CNT_W  = $clog2(FFT_LENGTH) + 1;
    localparam int EXP_W  = FFT_SCALE_FACTOR_WIDTH;
    localparam int CMP_W  = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(STAGES - 1);

    sched_state_e     state_q;
    logic [STG_W-1:0] stage_q;
    logic             rescale_en_q;
    logic             busy_q;
    logic             stage_done_q;
    logic             done_q;
    logic             err_q;
    logic             mode_q;
    logic [7:0]       thr_q;
    logic [EXP_W-1:0] scale_exp_q;

    logic [CNT_W-1:0] ovf_cnt;
    logic             last_sample;
    logic             start_acc;
    logic             abort_acc;
    logic             cnt_en;
    logic             cnt_clr;
    logic             last_stage;
    logic             over_thr;
    logic             exp_bump;

    assign start_acc  = (state_q == SCHED_IDLE) && bus.start_i && !bus.abort_i;
    assign abort_acc  = (state_q != SCHED_IDLE) && bus.abort_i;
    assign cnt_en     = (state_q == SCHED_RUN) && bus.sample_valid_i && !bus.abort_i;
    assign last_stage = (stage_q == LAST_STAGE);
    // The last stage keeps its overflow count visible until the next start.
    assign cnt_clr    = start_acc || abort_acc || ((state_q == SCHED_STAGE_END) && !last_stage);
    assign over_thr   = CMP_W'(ovf_cnt) > CMP_W'(thr_q);
    assign exp_bump   = (mode_q == RESCALE_MODE_ALWAYS) || (rescale_en_q && (ovf_cnt != '0));

    fft_stage_counter #(
        .LENGTH (FFT_LENGTH),
        .CNT_W  (CNT_W)
    ) u_stage_counter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .ovf         (bus.overflow_i),
        .last_sample (last_sample),
        .ovf_cnt     (ovf_cnt)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= SCHED_IDLE;
            stage_q      <= '0;
            rescale_en_q <= 1'b0;
            busy_q       <= 1'b0;
            stage_done_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mode_q       <= RESCALE_MODE_ADAPTIVE;
            thr_q        <= '0;
            scale_exp_q  <= '0;
        end else begin
            stage_done_q <= 1'b0;
            done_q       <= 1'b0;

            if (start_acc) begin
                err_q <= 1'b0;
            end else if (bus.sample_valid_i && (state_q != SCHED_RUN)) begin
                err_q <= 1'b1;
            end

            if (abort_acc) begin
                state_q      <= SCHED_IDLE;
                stage_q      <= '0;
                rescale_en_q <= 1'b0;
                busy_q       <= 1'b0;
                scale_exp_q  <= '0;
            end else begin
                case (state_q)
                    SCHED_IDLE: begin
                        if (start_acc) begin
                            state_q      <= SCHED_RUN;
                            stage_q      <= '0;
                            rescale_en_q <= 1'b1;
                            busy_q       <= 1'b1;
                            scale_exp_q  <= '0;
                            mode_q       <= bus.mode_i;
                            thr_q        <= bus.threshold_i;
                        end
                    end
                    SCHED_RUN: begin
                        if (cnt_en && last_sample) begin
                            state_q      <= SCHED_STAGE_END;
                            stage_done_q <= 1'b1;
                        end
                    end
                    SCHED_STAGE_END: begin
                        if (exp_bump && (scale_exp_q != '1)) begin
                            scale_exp_q <= scale_exp_q + EXP_W'(1);
                        end
                        if (last_stage) begin
                            state_q      <= SCHED_DONE;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            rescale_en_q <= 1'b0;
                        end else begin
                            state_q      <= SCHED_RUN;
                            stage_q      <= stage_q + STG_W'(1);
                            rescale_en_q <= (mode_q == RESCALE_MODE_ALWAYS) || over_thr;
                        end
                    end
                    SCHED_DONE: state_q <= SCHED_IDLE;
                    default:    state_q <= SCHED_IDLE;
                endcase
            end
        end
    end

    assign bus.stage_o          = stage_q;
    assign bus.rescale_en_o     = rescale_en_q;
    assign bus.scale_track_en_o = busy_q;
    assign bus.busy_o           = busy_q;
    assign bus.stage_done_o     = stage_done_q;
    assign bus.done_o           = done_q;
    assign bus.scale_exp_o      = scale_exp_q;
    assign bus.stage_ovf_cnt_o  = ovf_cnt;
    assign bus.err_o            = err_q;

endmodule

// File: tb/tb_fft_rescale_scheduler.sv
// Directed bench for fft_rescale_scheduler at FFT_LENGTH=16 (4 stages).
module tb_fft_rescale_scheduler;
    localparam int N      = 16;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_rescale_scheduler_if #(.FFT_LENGTH(N), .FFT_SCALE_FACTOR_WIDTH(8)) bus();

    fft_rescale_scheduler #(
        .FFT_LENGTH             (N),
        .FFT_SCALE_FACTOR_WIDTH (8)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic            mode;
        logic [7:0]      thr;
        logic [3:0][4:0] ovf;
        logic [3:0]      en;
        logic [7:0]      exp_exp;
        logic [4:0]      last_ovf;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mkvec(input logic mode, input int thr,
                                   input int o0, input int o1, input int o2, input int o3,
                                   input logic e0, input logic e1, input logic e2, input logic e3,
                                   input int exp_exp);
        vec_t v;
        v.mode     = mode;
        v.thr      = 8'(thr);
        v.ovf[0]   = 5'(o0);
        v.ovf[1]   = 5'(o1);
        v.ovf[2]   = 5'(o2);
        v.ovf[3]   = 5'(o3);
        v.en[0]    = e0;
        v.en[1]    = e1;
        v.en[2]    = e2;
        v.en[3]    = e3;
        v.exp_exp  = 8'(exp_exp);
        v.last_ovf = 5'(o3);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.stage_o, bus.rescale_en_o, bus.scale_track_en_o, bus.busy_o,
                    bus.stage_done_o, bus.done_o, bus.scale_exp_o, bus.stage_ovf_cnt_o, bus.err_o});
    endfunction

    task automatic run_samples(input int n, input int n_ovf);
        for (int i = 0; i < n; i++) begin
            bus.sample_valid_i = 1'b1;
            bus.overflow_i     = (i < n_ovf);
            step();
        end
        bus.sample_valid_i = 1'b0;
        bus.overflow_i     = 1'b0;
    endtask

    // Full transform from IDLE; optionally a stray valid during the DONE cycle.
    task automatic run_transform(input vec_t v, input logic stray);
        bus.mode_i      = v.mode;
        bus.threshold_i = v.thr;
        bus.start_i     = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("start_busy", bus.busy_o, 1);
        chk("start_track", bus.scale_track_en_o, 1);
        chk("start_err_clr", bus.err_o, 0);
        chk("start_exp_zero", bus.scale_exp_o, 0);
        for (int s = 0; s < STAGES; s++) begin
            chk("stage_idx", bus.stage_o, s);
            chk("rescale_en", bus.rescale_en_o, v.en[s]);
            run_samples(N, int'(v.ovf[s]));
            chk("stage_done", bus.stage_done_o, 1);
            chk("stage_ovf_cnt", bus.stage_ovf_cnt_o, v.ovf[s]);
            step();
            chk("stage_done_pulse", bus.stage_done_o, 0);
        end
        chk("done", bus.done_o, 1);
        chk("done_busy", bus.busy_o, 0);
        chk("done_exp", bus.scale_exp_o, v.exp_exp);
        chk("done_ovf_cnt", bus.stage_ovf_cnt_o, v.last_ovf);
        bus.sample_valid_i = stray;
        step();
        bus.sample_valid_i = 1'b0;
        chk("done_pulse", bus.done_o, 0);
        chk("exp_hold", bus.scale_exp_o, v.exp_exp);
        chk("ovf_hold", bus.stage_ovf_cnt_o, v.last_ovf);
        chk("err_after_done", bus.err_o, stray);
    endtask

    initial begin
        int done_seen;

        vecs[0] = mkvec(1'b1, 0,   0, 0, 0,  0,  1'b1, 1'b1, 1'b1, 1'b1, 4);
        vecs[1] = mkvec(1'b0, 2,   3, 0, 5,  1,  1'b1, 1'b1, 1'b0, 1'b1, 2);
        vecs[2] = mkvec(1'b0, 0,   0, 0, 0,  0,  1'b1, 1'b0, 1'b0, 1'b0, 0);
        vecs[3] = mkvec(1'b0, 3,   3, 4, 16, 2,  1'b1, 1'b0, 1'b1, 1'b1, 3);
        vecs[4] = mkvec(1'b1, 255, 16, 1, 0, 2,  1'b1, 1'b1, 1'b1, 1'b1, 4);

        rst                = 1'b1;
        bus.start_i        = 1'b0;
        bus.abort_i        = 1'b0;
        bus.mode_i         = 1'b0;
        bus.threshold_i    = '0;
        bus.sample_valid_i = 1'b0;
        bus.overflow_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 0);
        rst = 1'b0;
        step();
        chk("idle_outs", all_outs(), 0);

        // Table vectors back-to-back; odd entries leave err set to prove start clears it.
        for (int k = 0; k < 5; k++) begin
            run_transform(vecs[k], (k % 2) == 1);
        end

        // Protocol: stray overflow, start during RUN, valid in STAGE_END.
        bus.mode_i      = 1'b0;
        bus.threshold_i = 8'd0;
        bus.start_i     = 1'b1;
        step();
        bus.start_i = 1'b0;
        run_samples(2, 2);
        bus.overflow_i = 1'b1;
        repeat (3) step();
        bus.overflow_i = 1'b0;
        chk("ovf_without_valid", bus.stage_ovf_cnt_o, 2);
        bus.start_i        = 1'b1;
        bus.sample_valid_i = 1'b1;
        step();
        bus.start_i        = 1'b0;
        bus.sample_valid_i = 1'b0;
        chk("start_in_run_stage", bus.stage_o, 0);
        chk("start_in_run_busy", bus.busy_o, 1);
        chk("start_in_run_err", bus.err_o, 0);
        run_samples(12, 0);
        chk("proto_not_yet_done", bus.stage_done_o, 0);
        run_samples(1, 0);
        chk("proto_stage0_done", bus.stage_done_o, 1);
        chk("proto_stage0_ovf", bus.stage_ovf_cnt_o, 2);
        bus.sample_valid_i = 1'b1;
        step();
        bus.sample_valid_i = 1'b0;
        chk("valid_in_stage_end_err", bus.err_o, 1);
        chk("proto_stage1", bus.stage_o, 1);
        chk("proto_stage1_en", bus.rescale_en_o, 1);
        run_samples(15, 0);
        chk("stage_end_valid_not_counted", bus.stage_done_o, 0);
        run_samples(1, 0);
        chk("proto_stage1_done", bus.stage_done_o, 1);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk("abort_stage_end_busy", bus.busy_o, 0);
        chk("abort_keeps_err", bus.err_o, 1);

        // Abort at sample 7 of stage 2 in always mode.
        bus.mode_i  = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            run_samples(N, 0);
            step();
        end
        chk("pre_abort_exp", bus.scale_exp_o, 2);
        chk("pre_abort_stage", bus.stage_o, 2);
        run_samples(7, 1);
        chk("pre_abort_ovf", bus.stage_ovf_cnt_o, 1);
        bus.sample_valid_i = 1'b1;
        bus.abort_i        = 1'b1;
        step();
        bus.sample_valid_i = 1'b0;
        bus.abort_i        = 1'b0;
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_exp", bus.scale_exp_o, 0);
        chk("abort_stage", bus.stage_o, 0);
        chk("abort_en", bus.rescale_en_o, 0);
        chk("abort_ovf", bus.stage_ovf_cnt_o, 0);
        done_seen = int'(bus.done_o);
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done_o) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        run_transform(vecs[0], 1'b0);

        // Abort and start together in IDLE: abort wins.
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        chk("abort_start_idle_busy", bus.busy_o, 0);
        step();
        chk("abort_start_idle_stays", bus.busy_o, 0);

        // Asynchronous reset mid-RUN.
        bus.mode_i  = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        run_samples(N, 3);
        step();
        run_samples(5, 2);
        chk("pre_reset_busy", bus.busy_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outs", all_outs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("post_reset_outs", all_outs(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
